// File: rtl/lsu_banked_pkg.sv
// Shared definitions for the banked load/store unit: requester indices, arbitration
// mode encodings and the bank-select width helper.
package lsu_banked_pkg;

  localparam int unsigned REQ_AXI  = 0;
  localparam int unsigned REQ_SGB  = 1;
  localparam int unsigned REQ_CTRL = 2;
  localparam int unsigned REQ_ALU  = 3;

  localparam int unsigned ARB_FIXED = 0;
  localparam int unsigned ARB_RR    = 1;

  function automatic int unsigned bank_sel_width(input int unsigned num_banks);
    return $clog2(num_banks);
  endfunction

endpackage

// File: rtl/lsu_banked_arb.sv
// Per-bank request decode and arbiter (fixed priority or round-robin with pointer).
module lsu_bank_arb
  import lsu_banked_pkg::*;
#(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned BSW      = 2,
  parameter int unsigned IDX_W    = 2,
  parameter int unsigned BANK_ID  = 0,
  parameter int unsigned ARB_MODE = ARB_FIXED
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [NUM_REQ*BSW-1:0] sel,
  output logic [NUM_REQ-1:0]     gnt,
  output logic                   vld,
  output logic [IDX_W-1:0]       idx
);

  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [NUM_REQ-1:0] hit;
  logic [IDX_W-1:0]   cand;

  always_comb begin
    hit   = '0;
    gnt   = '0;
    vld   = 1'b0;
    idx   = '0;
    cand  = '0;
    ptr_d = ptr_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      hit[i] = req[i] && (sel[i*BSW +: BSW] == BSW'(BANK_ID));
    end
    // Search order starts at the pointer in round-robin mode, at index 0 otherwise.
    for (int k = 0; k < NUM_REQ; k++) begin
      if (ARB_MODE == ARB_RR) cand = IDX_W'((32'(ptr_q) + 32'(k)) % NUM_REQ);
      else                    cand = IDX_W'(k);
      if (!vld && hit[cand]) begin
        vld = 1'b1;
        idx = cand;
      end
    end
    if (rst) vld = 1'b0;
    if (vld) begin
      gnt[idx] = 1'b1;
      ptr_d    = (idx == IDX_W'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/lsu_banked_bram.sv
// Dual-port synchronous BRAM with registered read data on both ports.
module lsu_banked_bram #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  a_en,
  input  logic                  a_we,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  output logic [DATA_WIDTH-1:0] a_rdata,
  input  logic                  b_en,
  input  logic                  b_we,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  output logic [DATA_WIDTH-1:0] b_rdata
);

  logic [DATA_WIDTH-1:0] mem [0:(1 << ADDR_WIDTH)-1];

  always_ff @(posedge clk) begin
    if (a_en) begin
      if (a_we) mem[a_addr] <= a_wdata;
      a_rdata <= mem[a_addr];
    end
    if (b_en) begin
      if (b_we) mem[b_addr] <= b_wdata;
      b_rdata <= mem[b_addr];
    end
  end

endmodule

// File: rtl/lsu_banked.sv
// Banked local-memory load/store unit: per-bank arbitration, BRAM access and a
// two-stage read-return pipeline feeding registered per-requester read data.
module lsu_banked
  import lsu_banked_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned NUM_BANKS  = 4,
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned ARB_MODE   = ARB_FIXED
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_in,
  input  logic [NUM_REQ-1:0]            we_in,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] addr_in,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] wdata_in,
  output logic [NUM_REQ-1:0]            gnt_out,
  output logic [NUM_REQ-1:0]            rvalid_out,
  output logic [NUM_REQ*DATA_WIDTH-1:0] rdata_out,
  output logic [15:0]                   conflict_cnt_out
);

  localparam int unsigned BSW   = bank_sel_width(NUM_BANKS);
  localparam int unsigned LAW   = ADDR_WIDTH - BSW;
  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ*BSW-1:0]        sel;
  logic [NUM_REQ-1:0]            bank_gnt   [NUM_BANKS];
  logic                          bank_vld   [NUM_BANKS];
  logic                          bank_we    [NUM_BANKS];
  logic [IDX_W-1:0]              bank_idx   [NUM_BANKS];
  logic [DATA_WIDTH-1:0]         bank_rdata [NUM_BANKS];
  logic                          s1_vld_q   [NUM_BANKS];
  logic                          s2_vld_q   [NUM_BANKS];
  logic [IDX_W-1:0]              s1_idx_q   [NUM_BANKS];
  logic [IDX_W-1:0]              s2_idx_q   [NUM_BANKS];
  logic [NUM_REQ*DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [15:0]                   cnt_q, cnt_d;
  logic [NUM_REQ-1:0]            gnt_all, rvalid_d;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_sel
    assign sel[i*BSW +: BSW] = addr_in[i*ADDR_WIDTH + ADDR_WIDTH - 1 -: BSW];
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic [LAW-1:0]        laddr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [DATA_WIDTH-1:0] unused_b_rdata;

    lsu_bank_arb #(
      .NUM_REQ (NUM_REQ),
      .BSW     (BSW),
      .IDX_W   (IDX_W),
      .BANK_ID (b),
      .ARB_MODE(ARB_MODE)
    ) u_arb (
      .clk(clk),
      .rst(rst),
      .req(req_in),
      .sel(sel),
      .gnt(bank_gnt[b]),
      .vld(bank_vld[b]),
      .idx(bank_idx[b])
    );

    assign bank_we[b] = bank_vld[b] & we_in[bank_idx[b]];
    assign laddr      = addr_in[32'(bank_idx[b])*ADDR_WIDTH +: LAW];
    assign wdata      = wdata_in[32'(bank_idx[b])*DATA_WIDTH +: DATA_WIDTH];

    lsu_banked_bram #(
      .DATA_WIDTH(DATA_WIDTH),
      .ADDR_WIDTH(LAW)
    ) u_bram (
      .clk    (clk),
      .a_en   (bank_vld[b]),
      .a_we   (bank_we[b]),
      .a_addr (laddr),
      .a_wdata(wdata),
      .a_rdata(bank_rdata[b]),
      .b_en   (1'b0),
      .b_we   (1'b0),
      .b_addr ('0),
      .b_wdata('0),
      .b_rdata(unused_b_rdata)
    );
  end

  always_comb begin
    gnt_all  = '0;
    rvalid_d = '0;
    rdata_d  = rdata_q;
    for (int b = 0; b < NUM_BANKS; b++) begin
      gnt_all |= bank_gnt[b];
      if (s2_vld_q[b]) rvalid_d[s2_idx_q[b]] = 1'b1;
      // BRAM output is valid while the read sits in stage 1; capture it for stage 2.
      if (s1_vld_q[b]) rdata_d[32'(s1_idx_q[b])*DATA_WIDTH +: DATA_WIDTH] = bank_rdata[b];
    end
    cnt_d = cnt_q;
    if ((|(req_in & ~gnt_all)) && (cnt_q != 16'hFFFF)) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        s1_vld_q[b] <= 1'b0;
        s2_vld_q[b] <= 1'b0;
        s1_idx_q[b] <= '0;
        s2_idx_q[b] <= '0;
      end
      rdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        s1_vld_q[b] <= bank_vld[b] & ~bank_we[b];
        s1_idx_q[b] <= bank_idx[b];
        s2_vld_q[b] <= s1_vld_q[b];
        s2_idx_q[b] <= s1_idx_q[b];
      end
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs read as zero for every cycle reset is high, not only after the first edge.
  assign gnt_out          = gnt_all;
  assign rvalid_out       = rst ? '0 : rvalid_d;
  assign rdata_out        = rst ? '0 : rdata_q;
  assign conflict_cnt_out = rst ? '0 : cnt_q;

endmodule
